// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, default operand width, FSM state encoding and small op decoders.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opSel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Signed variants take operand magnitudes and re-apply signs at the end.
  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Divide ops share the upper encoding bit.
  function automatic logic isDivOp(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/Busy/Done request interface between the pipeline controller and the
// multiply/divide unit. The controller drives the request side (master), the
// unit returns status and the HI/LO results (slave).
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, OperandA, OperandB,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  Start, Op, OperandA, OperandB,
    output Busy, Done, DivZero, HI, LO
  );

endinterface

// File: rtl/mul_div_unit_signfix.sv
// Conditional two's-complement negation. With carryIn=1 this is a plain
// conditional negate (used for absolute values and single-word results).
// For the upper half of a double-word negate, carryIn carries the +1 in from
// the lower half, which only propagates when the lower word is zero.
module mul_div_unit_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             negate,
  input  logic             carryIn,
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] inverted;
  logic [WIDTH-1:0] increment;

  assign inverted  = negate ? ~dataIn : dataIn;
  assign increment = {{(WIDTH-1){1'b0}}, negate & carryIn};
  assign dataOut   = inverted + increment;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit. Operands are reduced to
// magnitudes at the Start edge, a shared accumulator datapath runs one
// radix-2 shift-add (multiply) or restoring-divide step per clock, and a
// final FIX cycle re-applies signs and writes HI/LO.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic           Clock,
  input logic           Reset,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state;
  state_e           stateNext;
  logic [CNT_W-1:0] count;

  // Operation context captured at the Start edge.
  logic [1:0]       opReg;
  logic [WIDTH-1:0] operandMag;
  logic [WIDTH-1:0] rawA;
  logic             resultNeg;
  logic             remNeg;
  logic             bZero;

  // Shared datapath: acc is the upper product half / partial remainder,
  // mq is the multiplier being consumed / quotient being built.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;

  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             doneReg;
  logic             divZeroReg;

  logic             accept;
  logic             signedIn;
  logic             isDivReg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] accStep;
  logic [WIDTH-1:0] mqStep;

  logic             hiNegate;
  logic             hiCarry;
  logic [WIDTH-1:0] hiFixed;
  logic [WIDTH-1:0] loFixed;

  assign signedIn = isSignedOp(bus.Op);
  assign isDivReg = isDivOp(opReg);

  mul_div_unit_signfix #(.WIDTH(WIDTH)) uAbsA (
    .dataIn  (bus.OperandA),
    .negate  (signedIn & bus.OperandA[WIDTH-1]),
    .carryIn (1'b1),
    .dataOut (absA)
  );

  mul_div_unit_signfix #(.WIDTH(WIDTH)) uAbsB (
    .dataIn  (bus.OperandB),
    .negate  (signedIn & bus.OperandB[WIDTH-1]),
    .carryIn (1'b1),
    .dataOut (absB)
  );

  // Next-state logic and the accept strobe for a new request.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          stateNext = CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          stateNext = FIX;
        end
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // One iteration step of either algorithm, computed from the current acc/mq.
  always_comb begin
    mulSum   = {1'b0, acc} + {1'b0, (mq[0] ? operandMag : {WIDTH{1'b0}})};
    divTrial = {acc, mq[WIDTH-1]} - {1'b0, operandMag};
    if (isDivReg) begin
      // Partial remainder stays below the divisor, so the shifted value's
      // top bit is always captured in divTrial and never lost from acc.
      if (!divTrial[WIDTH]) begin
        accStep = divTrial[WIDTH-1:0];
        mqStep  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        accStep = {acc[WIDTH-2:0], mq[WIDTH-1]};
        mqStep  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      accStep = mulSum[WIDTH:1];
      mqStep  = {mulSum[0], mq[WIDTH-1:1]};
    end
  end

  // Sign restoration: the product is negated as a double word, so the upper
  // half only takes the +1 when the lower half is zero. The remainder follows
  // the dividend's sign, the quotient follows the operand sign difference.
  assign hiNegate = isDivReg ? remNeg : resultNeg;
  assign hiCarry  = isDivReg | (mq == '0);

  mul_div_unit_signfix #(.WIDTH(WIDTH)) uFixHi (
    .dataIn  (acc),
    .negate  (hiNegate),
    .carryIn (hiCarry),
    .dataOut (hiFixed)
  );

  mul_div_unit_signfix #(.WIDTH(WIDTH)) uFixLo (
    .dataIn  (mq),
    .negate  (resultNeg),
    .carryIn (1'b1),
    .dataOut (loFixed)
  );

  // Operand capture at the Start edge and the per-cycle iteration.
  always_ff @(posedge Clock) begin
    if (accept) begin
      opReg      <= bus.Op;
      operandMag <= absB;
      rawA       <= bus.OperandA;
      resultNeg  <= signedIn & (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
      remNeg     <= signedIn & bus.OperandA[WIDTH-1];
      bZero      <= (bus.OperandB == '0);
      acc        <= '0;
      mq         <= absA;
    end else if (state == CALC) begin
      acc <= accStep;
      mq  <= mqStep;
    end
  end

  // Iteration counter, result registers and the Done/DivZero flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            count <= CNT_W'(WIDTH - 1);
          end
        end
        CALC: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end
        end
        FIX: begin
          doneReg    <= 1'b1;
          divZeroReg <= isDivReg & bZero;
          // Divide by zero returns the raw dividend and an all-ones quotient
          // rather than the sign-corrected algorithm output.
          if (isDivReg && bZero) begin
            hiReg <= rawA;
            loReg <= '1;
          end else begin
            hiReg <= hiFixed;
            loReg <= loFixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = doneReg;
  assign bus.DivZero = divZeroReg;
  assign bus.HI      = hiReg;
  assign bus.LO      = loReg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: fixed vectors, hand-written handshake
// sequences and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t        vecs[11];
  int          tests    = 0;
  int          failures = 0;
  logic [31:0] lastHi   = '0;
  logic [31:0] lastLo   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, % follows dividend.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT:  begin prod = sa * sb; hi = prod[63:32]; lo = prod[31:0]; end
      OP_MULTU: begin prod = ua * ub; hi = prod[63:32]; lo = prod[31:0]; end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFFFFFF; dz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb; r = sa % sb;
          lo = 32'(q); hi = 32'(r);
        end else begin
          lo = 32'(ua / ub); hi = 32'(ua % ub);
        end
      end
    endcase
  endfunction

  // Advance from the current edge count until Done is seen or the budget expires.
  task automatic waitDone(inout int edges, output bit seen);
    seen = 1'b0;
    while (edges < 40) begin
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
    if (!seen && bus.Done) seen = 1'b1;
  endtask

  // One full transaction with latency, Busy width, hold and result checks.
  task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo, input logic expDz);
    int edges;
    int busyCycles;
    bit seen;
    bit holdOk;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.Op = 2'($urandom); bus.OperandA = $urandom; bus.OperandB = $urandom;
    edges = 1; busyCycles = 0; seen = 1'b0; holdOk = 1'b1;
    while (edges <= 40) begin
      if (bus.Done) begin
        seen = 1'b1;
        break;
      end
      if (bus.Busy) busyCycles++;
      if (bus.HI !== lastHi || bus.LO !== lastLo) holdOk = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    check($sformatf("%s done seen", name), seen, 1);
    check($sformatf("%s latency", name), edges, 34);
    check($sformatf("%s busy cycles", name), busyCycles, 33);
    check($sformatf("%s hi/lo held", name), holdOk, 1);
    check($sformatf("%s busy in done", name), bus.Busy, 0);
    check($sformatf("%s HI", name), bus.HI, expHi);
    check($sformatf("%s LO", name), bus.LO, expLo);
    check($sformatf("%s DivZero", name), bus.DivZero, expDz);
    @(posedge clk); #1;
    check($sformatf("%s done pulse", name), bus.Done, 0);
    check($sformatf("%s DivZero held", name), bus.DivZero, expDz);
    lastHi = expHi;
    lastLo = expLo;
  endtask

  initial begin
    #400000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          edges;
    int          doneCount;
    bit          seen;
    logic [1:0]  op;
    logic [31:0] a, b, eHi, eLo;
    logic        eDz;
    int          sel;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIVU,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULTU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};

    rst = 1'b1;
    bus.Start = 1'b0; bus.Op = OP_MULT; bus.OperandA = '0; bus.OperandB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Busy", bus.Busy, 0);
    check("reset Done", bus.Done, 0);
    check("reset DivZero", bus.DivZero, 0);
    check("reset HI", bus.HI, 0);
    check("reset LO", bus.LO, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // Start asserted in the Done cycle is accepted immediately.
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd6; bus.OperandB = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    edges = 1;
    waitDone(edges, seen);
    check("doneStart first done", seen, 1);
    check("doneStart first LO", bus.LO, 42);
    bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 32'd100; bus.OperandB = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    check("doneStart Done falls", bus.Done, 0);
    check("doneStart Busy", bus.Busy, 1);
    edges = 1;
    waitDone(edges, seen);
    check("doneStart second done", seen, 1);
    check("doneStart second latency", edges, 34);
    check("doneStart second HI", bus.HI, 2);
    check("doneStart second LO", bus.LO, 14);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd6; bus.OperandB = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    edges = 1;
    while (edges < 10) begin @(posedge clk); #1; edges++; end
    bus.Start = 1'b1; bus.Op = OP_DIV; bus.OperandA = 32'h0000DEAD; bus.OperandB = 32'd3;
    @(posedge clk); #1;
    edges++;
    bus.Start = 1'b0;
    waitDone(edges, seen);
    check("busyStart done", seen, 1);
    check("busyStart latency", edges, 34);
    check("busyStart HI", bus.HI, 0);
    check("busyStart LO", bus.LO, 42);
    doneCount = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.Done) doneCount++; end
    check("busyStart no extra done", doneCount, 0);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'h0000FFFF; bus.OperandB = 32'h0000FFFF;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    edges = 1;
    while (edges < 20) begin @(posedge clk); #1; edges++; end
    check("midReset busy before", bus.Busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midReset Busy", bus.Busy, 0);
    check("midReset Done", bus.Done, 0);
    check("midReset HI", bus.HI, 0);
    check("midReset LO", bus.LO, 0);
    doneCount = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.Done) doneCount++; end
    check("midReset no done", doneCount, 0);
    lastHi = '0;
    lastLo = '0;

    // Reset wins over a simultaneous Start.
    @(negedge clk);
    rst = 1'b1;
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd3; bus.OperandB = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.Start = 1'b0;
    check("resetStart Busy", bus.Busy, 0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       begin b = 32'hFFFFFFFF; a = 32'h80000000; end
        default: b = $urandom;
      endcase
      refModel(op, a, b, eHi, eLo, eDz);
      runOp($sformatf("rand%0d op%0d a=%0h b=%0h", i, op, a, b), op, a, b, eHi, eLo, eDz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
